dcache_fill_ctrl: RTL and testbench
===================================

// Module: dcache_fill_ctrl
// PURPOSE
//  Miss/fill controller driving the write port of the 128x64 direct-mapped dcache data array.
//  Detects load misses, issues BUS_LOAD requests to memory and tracks outstanding tags in an MSHR table.
//  Sends each returned memory line into the cache as a one-cycle write.
//  Sits between the LSQ load-lookup path, the dcache array and the memory bus.
// PARAMETERS
//  NUM_MSHR   4    outstanding miss entries; must be 1..15
// PORTS
//  clock            in   1   system clock
//  reset            in   1   synchronous, active-high
//  ld_req           in   1   load lookup this cycle
//  ld_addr          in   64  load byte address; same value drives cache rd_pc_reg
//  cache_hit        in   1   cache rd_valid for ld_addr
//  mem2proc_response in  4   memory accept tag for current command; 0 = rejected/busy
//  mem2proc_data    in   64  returned line data
//  mem2proc_tag     in   4   tag of returned data; 0 = no data this cycle
//  proc2mem_command out  2   BUS_NONE=0, BUS_LOAD=1 (BUS_STORE never issued)
//  proc2mem_addr    out  64  {line_addr[63:3],3'b000}
//  wr_en            out  1   cache fill strobe
//  wr_data          out  64  cache fill data
//  wr_pc_reg        out  64  cache fill address (line aligned)
//  ld_stall         out  1   miss seen but cannot be accepted this cycle; LSQ replays
//  mshr_full        out  1   all NUM_MSHR entries valid
// BEHAVIOUR
//  Reset: state IDLE, all MSHR valid=0, pending req cleared; all outputs 0 (command BUS_NONE).
//  Line address = addr[63:3]; all compares on line address only.
//  Miss = ld_req & ~cache_hit. Merge: if line matches a valid MSHR entry or the pending
//   request, no new request, ld_stall=0.
//  Accept new miss only in IDLE and with >=1 free MSHR (from registered state); else ld_stall=1
//   (combinational, same cycle). Accepted miss latches req_addr, state -> REQ next edge.
//  REQ: proc2mem_command=BUS_LOAD, proc2mem_addr from req_addr. If mem2proc_response!=0:
//   allocate lowest-index free entry {valid=1, tag=response, line}, state -> IDLE at edge.
//   If response==0: hold REQ, re-drive identical command next cycle.
//  Fill: mem2proc_tag!=0 matching a valid entry -> next cycle wr_en=1, wr_data=mem2proc_data,
//   wr_pc_reg={line,3'b0}; entry valid cleared at same edge. wr_en is a one-cycle pulse;
//   back-to-back tags give back-to-back pulses.
//  Unmatched mem2proc_tag (0, stale, duplicate) ignored: no wr_en, no state change.
//  Tag match uses pre-edge table; allocation and free may occur same edge on distinct entries.
//  Freed entry is allocatable the following cycle, not the same cycle (no bypass).
//  Miss to a line whose fill wr_en is currently asserted: treated as new miss (no bypass).
//  Reset mid-operation: table cleared; later returns for old tags ignored; REQ abandoned.
//  Memory guarantees unique nonzero tags among outstanding requests; not checked.
// STRUCTURE
//  Shared package: BUS_NONE/BUS_LOAD/BUS_STORE encodings, MSHR entry struct {valid,tag[3:0],
//   line[60:0]}, state enum {IDLE,REQ}.
//  One sub-module: dcache_mshr_table (NUM_MSHR entries; CAM match on line and on tag,
//   lowest-free priority encoder, alloc/free ports). FSM and fill register live in top.
// TESTING
//  Miss 0x1008, response=3, later tag=3 data=0xDEAD -> one BUS_LOAD addr 0x1008; next cycle
//   wr_en=1, wr_pc_reg=0x1008, wr_data=0xDEAD; entry freed.
//  Response 0 for 3 cycles then 5 -> BUS_LOAD held 4 cycles same addr; one entry, tag 5.
//  Miss 0x2000 then 0x2004 while outstanding -> single BUS_LOAD, ld_stall=0 both, one fill.
//  Misses to 4 distinct lines (tags 1-4) -> mshr_full=1; 5th miss ld_stall=1; tag 2 returns
//   -> entry freed, 5th miss accepted the cycle after.
//  Tag 7 arrives with no matching entry; tag 0 with data -> no wr_en, table unchanged.
//  Reset with 2 outstanding, then old tags return -> no wr_en, mshr_full=0, command BUS_NONE.

Source files
------------

// File: rtl/dcache_fill_ctrl_pkg.sv
// Shared definitions for the dcache miss/fill controller.
//   bus_cmd_e     : memory bus command encodings (BUS_STORE is never issued here)
//   fill_state_e  : request FSM states
//   mshr_entry_t  : one outstanding-miss entry {valid, tag, line}
//   line_to_addr  : expands a 61-bit line number to a line-aligned byte address
package dcache_fill_ctrl_pkg;

  localparam int unsigned LINE_W = 61;
  localparam int unsigned TAG_W  = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fill_state_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] line;
  } mshr_entry_t;

  function automatic logic [63:0] line_to_addr(input logic [LINE_W-1:0] line);
    return {line, 3'b000};
  endfunction

endpackage

// File: rtl/dcache_fill_ctrl_if.sv
// Bundle of the LSQ lookup, memory bus and dcache write-port signals seen by
// the fill controller.
//   master : the fill controller (consumes lookups/memory replies, drives
//            memory commands, cache fill port, stall and full flags)
//   slave  : the surrounding LSQ / memory / cache environment
interface dcache_fill_ctrl_if;
  import dcache_fill_ctrl_pkg::*;

  logic        ld_req;
  logic [63:0] ld_addr;
  logic        cache_hit;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  bus_cmd_e    proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic        wr_en;
  logic [63:0] wr_data;
  logic [63:0] wr_pc_reg;
  logic        ld_stall;
  logic        mshr_full;

  modport master (
    input  ld_req, ld_addr, cache_hit,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output proc2mem_command, proc2mem_addr,
    output wr_en, wr_data, wr_pc_reg,
    output ld_stall, mshr_full
  );

  modport slave (
    output ld_req, ld_addr, cache_hit,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  proc2mem_command, proc2mem_addr,
    input  wr_en, wr_data, wr_pc_reg,
    input  ld_stall, mshr_full
  );

endinterface

// File: rtl/dcache_mshr_table.sv
// Miss status holding register table for the dcache fill controller.
// Ports:
//   clock, reset                  : system clock, synchronous active-high reset
//   lookup_line_i / line_hit_o    : CAM match of a line against valid entries
//   fill_tag_i / tag_hit_o,
//   tag_idx_o, tag_line_o         : CAM match of a returned tag (tag 0 never hits)
//   free_en_i, free_idx_i         : clear an entry's valid bit at the edge
//   alloc_en_i, alloc_tag_i,
//   alloc_line_i                  : write the lowest-index free entry at the edge
//   free_avail_o, full_o          : at least one free entry / all entries valid
// All outputs reflect the registered table only, so a slot freed this cycle
// cannot be reused until the next one.
module dcache_mshr_table
  import dcache_fill_ctrl_pkg::*;
#(
  parameter int unsigned NUM_MSHR = 4,
  localparam int unsigned IDX_W = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [LINE_W-1:0] lookup_line_i,
  output logic              line_hit_o,
  input  logic [TAG_W-1:0]  fill_tag_i,
  output logic              tag_hit_o,
  output logic [IDX_W-1:0]  tag_idx_o,
  output logic [LINE_W-1:0] tag_line_o,
  input  logic              free_en_i,
  input  logic [IDX_W-1:0]  free_idx_i,
  input  logic              alloc_en_i,
  input  logic [TAG_W-1:0]  alloc_tag_i,
  input  logic [LINE_W-1:0] alloc_line_i,
  output logic              free_avail_o,
  output logic              full_o
);

  mshr_entry_t ent_q [NUM_MSHR];
  mshr_entry_t ent_d [NUM_MSHR];

  logic             alloc_found;
  logic [IDX_W-1:0] alloc_idx;

  always_comb begin
    line_hit_o  = 1'b0;
    tag_hit_o   = 1'b0;
    tag_idx_o   = '0;
    tag_line_o  = '0;
    alloc_found = 1'b0;
    alloc_idx   = '0;
    full_o      = 1'b1;
    for (int unsigned i = 0; i < NUM_MSHR; i++) begin
      if (ent_q[i].valid && ent_q[i].line == lookup_line_i) begin
        line_hit_o = 1'b1;
      end
      // First match wins; memory keeps live tags unique so at most one hits.
      if (!tag_hit_o && ent_q[i].valid && fill_tag_i != '0 &&
          ent_q[i].tag == fill_tag_i) begin
        tag_hit_o  = 1'b1;
        tag_idx_o  = IDX_W'(i);
        tag_line_o = ent_q[i].line;
      end
      if (!ent_q[i].valid) begin
        full_o = 1'b0;
        if (!alloc_found) begin
          alloc_found = 1'b1;
          alloc_idx   = IDX_W'(i);
        end
      end
    end
    free_avail_o = alloc_found;
  end

  // Alloc targets a pre-edge free slot and free targets a pre-edge valid slot,
  // so both may land on the same edge without colliding.
  always_comb begin
    for (int unsigned i = 0; i < NUM_MSHR; i++) begin
      ent_d[i] = ent_q[i];
      if (free_en_i && free_idx_i == IDX_W'(i)) begin
        ent_d[i].valid = 1'b0;
      end
      if (alloc_en_i && alloc_found && alloc_idx == IDX_W'(i)) begin
        ent_d[i] = '{valid: 1'b1, tag: alloc_tag_i, line: alloc_line_i};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_MSHR; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_MSHR; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

endmodule

// File: rtl/dcache_fill_ctrl.sv
// Miss/fill controller for the 128x64 direct-mapped dcache data array.
// Ports:
//   clock  : system clock
//   reset  : synchronous, active-high
//   bus    : dcache_fill_ctrl_if.master
//            inputs  ld_req, ld_addr, cache_hit, mem2proc_response,
//                    mem2proc_data, mem2proc_tag
//            outputs proc2mem_command, proc2mem_addr, wr_en, wr_data,
//                    wr_pc_reg, ld_stall, mshr_full
// A load miss to a line not already outstanding is latched and driven as a
// BUS_LOAD until memory accepts it with a nonzero tag; the tag is then kept in
// the MSHR table. A returned tag matching a live entry produces a one-cycle
// cache write of the line on the following cycle and frees the entry.
module dcache_fill_ctrl
  import dcache_fill_ctrl_pkg::*;
#(
  parameter int unsigned NUM_MSHR = 4
) (
  input  logic               clock,
  input  logic               reset,
  dcache_fill_ctrl_if.master bus
);

  localparam int unsigned IDX_W = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;

  fill_state_e       state_q, state_d;
  logic [LINE_W-1:0] req_line_q, req_line_d;
  logic              wr_en_q, wr_en_d;
  logic [63:0]       wr_data_q, wr_data_d;
  logic [63:0]       wr_pc_q, wr_pc_d;

  logic [LINE_W-1:0] ld_line;
  logic              miss, pend_hit, line_hit, new_miss, can_accept, accept;
  logic              alloc_en;
  logic              tag_hit;
  logic [IDX_W-1:0]  tag_idx;
  logic [LINE_W-1:0] tag_line;
  logic              free_avail, full;
  logic              unused_addr_bits;

  assign ld_line          = bus.ld_addr[63:3];
  assign unused_addr_bits = ^bus.ld_addr[2:0];

  dcache_mshr_table #(
    .NUM_MSHR(NUM_MSHR)
  ) u_mshr (
    .clock        (clock),
    .reset        (reset),
    .lookup_line_i(ld_line),
    .line_hit_o   (line_hit),
    .fill_tag_i   (bus.mem2proc_tag),
    .tag_hit_o    (tag_hit),
    .tag_idx_o    (tag_idx),
    .tag_line_o   (tag_line),
    .free_en_i    (tag_hit),
    .free_idx_i   (tag_idx),
    .alloc_en_i   (alloc_en),
    .alloc_tag_i  (bus.mem2proc_response),
    .alloc_line_i (req_line_q),
    .free_avail_o (free_avail),
    .full_o       (full)
  );

  // A miss already covered by a live entry or by the request still being
  // driven merges silently; anything else needs the FSM idle and a free slot.
  assign miss       = bus.ld_req & ~bus.cache_hit;
  assign pend_hit   = (state_q == REQ) && (req_line_q == ld_line);
  assign new_miss   = miss & ~(line_hit | pend_hit);
  assign can_accept = (state_q == IDLE) & free_avail;
  assign accept     = new_miss & can_accept;
  assign alloc_en   = (state_q == REQ) && (bus.mem2proc_response != '0);

  always_comb begin
    state_d    = state_q;
    req_line_d = req_line_q;
    wr_en_d    = tag_hit;
    wr_data_d  = wr_data_q;
    wr_pc_d    = wr_pc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = REQ;
          req_line_d = ld_line;
        end
      end
      REQ: begin
        if (alloc_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (tag_hit) begin
      wr_data_d = bus.mem2proc_data;
      wr_pc_d   = line_to_addr(tag_line);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      req_line_q <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      wr_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_line_q <= req_line_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      wr_pc_q    <= wr_pc_d;
    end
  end

  assign bus.proc2mem_command = (state_q == REQ) ? BUS_LOAD : BUS_NONE;
  assign bus.proc2mem_addr    = (state_q == REQ) ? line_to_addr(req_line_q) : '0;
  assign bus.wr_en            = wr_en_q;
  assign bus.wr_data          = wr_data_q;
  assign bus.wr_pc_reg        = wr_pc_q;
  assign bus.ld_stall         = new_miss & ~can_accept;
  assign bus.mshr_full        = full;

endmodule

// File: tb/tb_dcache_fill_ctrl.sv
// Scoreboard bench for dcache_fill_ctrl: a transaction-level model (list of
// outstanding {tag,line}, one pending request) predicts each cycle's memory
// command, stall/full response and the fill write one cycle later; a monitor
// on the falling edge pops and compares whenever the DUT presents them.
module tb_dcache_fill_ctrl;
  import dcache_fill_ctrl_pkg::*;

  localparam int unsigned NUM_MSHR = 4;

  typedef struct {
    logic [3:0]  tag;
    logic [60:0] line;
  } out_t;
  typedef struct {
    bit stall;
    bit full;
  } ld_exp_t;
  typedef struct {
    logic [63:0] data;
    logic [63:0] pc;
  } fill_exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dcache_fill_ctrl_if bus ();

  dcache_fill_ctrl #(.NUM_MSHR(NUM_MSHR)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  out_t        outst[$];
  bit          pend = 1'b0;
  logic [60:0] pend_line = '0;

  logic [63:0] exp_cmd_q[$];
  ld_exp_t     exp_ld_q[$];
  fill_exp_t   exp_fill_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Nonzero tag not live in memory's view and not the one returning this cycle.
  function automatic logic [3:0] pick_tag(input logic [3:0] avoid);
    logic [3:0] t;
    bit used;
    for (int n = 0; n < 64; n++) begin
      t = 4'($urandom_range(1, 15));
      used = (t == avoid);
      foreach (outst[i]) if (outst[i].tag == t) used = 1'b1;
      if (!used) return t;
    end
    return 4'd0;
  endfunction

  // Drive one cycle of inputs, predict outcomes from pre-edge model state,
  // then advance the model to its post-edge state.
  task automatic cycle(input bit req, input logic [63:0] addr, input bit hit,
                       input logic [3:0] resp, input logic [3:0] tag,
                       input logic [63:0] data);
    logic [60:0] line;
    bit merged, full, stall, accept;
    int fidx;
    bus.ld_req = req;
    bus.ld_addr = addr;
    bus.cache_hit = hit;
    bus.mem2proc_response = resp;
    bus.mem2proc_tag = tag;
    bus.mem2proc_data = data;
    line = addr[63:3];
    accept = 1'b0;
    if (pend) exp_cmd_q.push_back({pend_line, 3'b000});
    if (req && !hit) begin
      merged = pend && (pend_line == line);
      foreach (outst[i]) if (outst[i].line == line) merged = 1'b1;
      full = (outst.size() == NUM_MSHR);
      stall = !merged && (pend || full);
      accept = !merged && !stall;
      exp_ld_q.push_back('{stall: stall, full: full});
    end
    fidx = -1;
    if (tag != 4'd0) foreach (outst[i]) if (fidx < 0 && outst[i].tag == tag) fidx = i;
    if (fidx >= 0) begin
      exp_fill_q.push_back('{data: data, pc: {outst[fidx].line, 3'b000}});
      outst.delete(fidx);
    end
    if (pend && resp != 4'd0) begin
      outst.push_back('{tag: resp, line: pend_line});
      pend = 1'b0;
    end
    if (accept) begin
      pend = 1'b1;
      pend_line = line;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 64'd0, 1'b0, 4'd0, 4'd0, 64'd0);
  endtask

  task automatic do_reset();
    bus.ld_req = 1'b0;
    bus.mem2proc_tag = 4'd0;
    bus.mem2proc_response = 4'd0;
    reset = 1'b1;
    if (pend) exp_cmd_q.push_back({pend_line, 3'b000});
    @(posedge clock);
    #1;
    reset = 1'b0;
    outst.delete();
    pend = 1'b0;
    check("rst_command", 64'(bus.proc2mem_command), 64'(BUS_NONE));
    check("rst_addr", bus.proc2mem_addr, 64'd0);
    check("rst_wr_en", 64'(bus.wr_en), 64'd0);
    check("rst_full", 64'(bus.mshr_full), 64'd0);
    check("rst_stall", 64'(bus.ld_stall), 64'd0);
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (bus.proc2mem_command == BUS_LOAD) begin
        if (exp_cmd_q.size() == 0) fail("cmd_unexpected");
        else check("cmd_addr", bus.proc2mem_addr, exp_cmd_q.pop_front());
      end else begin
        check("cmd_none", 64'(bus.proc2mem_command), 64'(BUS_NONE));
        if (exp_cmd_q.size() != 0) begin
          fail("cmd_missing");
          void'(exp_cmd_q.pop_front());
        end
      end
      if (bus.wr_en) begin
        if (exp_fill_q.size() == 0) fail("fill_unexpected");
        else begin
          fill_exp_t f;
          f = exp_fill_q.pop_front();
          check("fill_data", bus.wr_data, f.data);
          check("fill_pc", bus.wr_pc_reg, f.pc);
        end
      end
      if (bus.ld_req && !bus.cache_hit) begin
        if (exp_ld_q.size() == 0) fail("ld_unexpected");
        else begin
          ld_exp_t e;
          e = exp_ld_q.pop_front();
          check("ld_stall", 64'(bus.ld_stall), 64'(e.stall));
          check("mshr_full", 64'(bus.mshr_full), 64'(e.full));
        end
      end else begin
        check("stall_idle", 64'(bus.ld_stall), 64'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, d;
    logic [3:0] rt, rs;
    bus.ld_req = 1'b0;
    bus.ld_addr = '0;
    bus.cache_hit = 1'b0;
    bus.mem2proc_response = '0;
    bus.mem2proc_tag = '0;
    bus.mem2proc_data = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    mon_en = 1'b1;
    do_reset();

    // Single miss, fill, then immediate re-miss of the line being written.
    cycle(1, 64'h1008, 0, 4'd0, 4'd0, 64'd0);
    cycle(0, 64'h0, 0, 4'd3, 4'd0, 64'd0);
    idle(2);
    cycle(0, 64'h0, 0, 4'd0, 4'd3, 64'hDEAD);
    cycle(1, 64'h1008, 0, 4'd0, 4'd0, 64'd0);
    cycle(0, 64'h0, 0, 4'd4, 4'd0, 64'd0);
    cycle(0, 64'h0, 0, 4'd0, 4'd4, 64'hBEEF);
    idle(1);

    // Memory busy three cycles, then accepts with tag 5.
    cycle(1, 64'h3000, 0, 4'd0, 4'd0, 64'd0);
    cycle(0, 64'h0, 0, 4'd0, 4'd0, 64'd0);
    cycle(0, 64'h0, 0, 4'd0, 4'd0, 64'd0);
    cycle(0, 64'h0, 0, 4'd0, 4'd0, 64'd0);
    cycle(0, 64'h0, 0, 4'd5, 4'd0, 64'd0);
    cycle(0, 64'h0, 0, 4'd0, 4'd5, 64'h5555);
    idle(1);

    // Same-line misses merge against the pending request and the table.
    cycle(1, 64'h2000, 0, 4'd0, 4'd0, 64'd0);
    cycle(1, 64'h2004, 0, 4'd0, 4'd0, 64'd0);
    cycle(1, 64'h2004, 0, 4'd6, 4'd0, 64'd0);
    cycle(1, 64'h2000, 0, 4'd0, 4'd0, 64'd0);
    cycle(0, 64'h0, 0, 4'd0, 4'd6, 64'h6666);
    idle(1);

    // Fill the table, stall a fifth miss, free tag 2, retry next cycle.
    for (int k = 1; k <= 4; k++) begin
      cycle(1, 64'h8000 + 64'(k) * 64'h40, 0, 4'd0, 4'd0, 64'd0);
      cycle(0, 64'h0, 0, 4'(k), 4'd0, 64'd0);
    end
    cycle(1, 64'h9000, 0, 4'd0, 4'd2, 64'h2222);
    cycle(1, 64'h9000, 0, 4'd0, 4'd0, 64'd0);
    cycle(0, 64'h0, 0, 4'd9, 4'd1, 64'h1111);
    // Stale / zero tags must not produce writes.
    cycle(0, 64'h0, 0, 4'd0, 4'd7, 64'h7777);
    cycle(0, 64'h0, 0, 4'd0, 4'd0, 64'hFFFF);
    cycle(0, 64'h0, 0, 4'd0, 4'd3, 64'h3333);
    cycle(0, 64'h0, 0, 4'd0, 4'd4, 64'h4444);
    cycle(0, 64'h0, 0, 4'd0, 4'd9, 64'h9999);
    idle(1);

    // Reset with two outstanding and a request in flight; old tags return.
    cycle(1, 64'h5000, 0, 4'd0, 4'd0, 64'd0);
    cycle(0, 64'h0, 0, 4'd10, 4'd0, 64'd0);
    cycle(1, 64'h5040, 0, 4'd0, 4'd0, 64'd0);
    cycle(0, 64'h0, 0, 4'd11, 4'd0, 64'd0);
    cycle(1, 64'h5080, 0, 4'd0, 4'd0, 64'd0);
    do_reset();
    cycle(0, 64'h0, 0, 4'd0, 4'd10, 64'hAAAA);
    cycle(0, 64'h0, 0, 4'd0, 4'd11, 64'hBBBB);
    cycle(1, 64'h5000, 0, 4'd0, 4'd0, 64'd0);
    cycle(0, 64'h0, 0, 4'd12, 4'd0, 64'd0);
    cycle(0, 64'h0, 0, 4'd0, 4'd12, 64'hCCCC);
    idle(1);

    // Randomized traffic over a small line pool so merges and stalls occur.
    for (int n = 0; n < 600; n++) begin
      a = 64'h4000 + 64'($urandom_range(0, 11)) * 64'd8 + 64'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) a = {$urandom, $urandom};
      d = {$urandom, $urandom};
      rt = 4'd0;
      if (outst.size() > 0 && $urandom_range(0, 2) == 0)
        rt = outst[$urandom_range(0, outst.size() - 1)].tag;
      else if ($urandom_range(0, 3) == 0)
        rt = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 1) == 0) ? pick_tag(rt) : 4'd0;
      cycle($urandom_range(0, 9) < 6, a, $urandom_range(0, 9) < 3, rs, rt, d);
    end
    idle(2);

    if (exp_cmd_q.size() != 0) fail("cmd_leftover");
    if (exp_ld_q.size() != 0) fail("ld_leftover");
    if (exp_fill_q.size() != 0) fail("fill_leftover");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
